// File: rtl/watchdog_pkg.sv
// Shared FSM definitions for the square / square-root blocks.
// The state encoding is common so both blocks decode identically.
package watchdog_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIN  = 3'd2
  } fsm_state_e;

endpackage

// File: rtl/cordic_square_if.sv
// Request/response bundle for cordic_square.
// The master drives the operands and start; the slave returns the result.
interface cordic_square_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 2 * IN_WIDTH
);

  logic                        start;
  logic        [IN_WIDTH-1:0]  y_in;
  logic signed [OUT_WIDTH-1:0] x_ref;
  logic        [OUT_WIDTH-1:0] sq_out;
  logic                        done;
  logic                        busy;
  logic                        check_ok;

  modport master (
    output start, y_in, x_ref,
    input  sq_out, done, busy, check_ok
  );

  modport slave (
    input  start, y_in, x_ref,
    output sq_out, done, busy, check_ok
  );

endinterface

// File: rtl/cordic_square_bound_check.sv
// sq_bound_check: combinational test that x_ref lies in [sq, sq + 2*y + 1).
// A negative reference only passes for a zero root, mirroring how the
// square-root block reports negative radicands. One extra bit of headroom
// keeps sq + 2*y + 1 from wrapping at the largest root.
module sq_bound_check #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 2 * IN_WIDTH
) (
  input  logic        [OUT_WIDTH-1:0] sq,
  input  logic        [IN_WIDTH-1:0]  y,
  input  logic signed [OUT_WIDTH-1:0] x_ref,
  output logic                        ok
);

  logic [OUT_WIDTH:0] sq_ext;
  logic [OUT_WIDTH:0] x_ext;
  logic [OUT_WIDTH:0] hi_ext;

  // Widen operands and evaluate the half-open bound.
  always_comb begin
    sq_ext = {1'b0, sq};
    x_ext  = {1'b0, x_ref};
    hi_ext = sq_ext + ((OUT_WIDTH + 1)'(y) << 1) + (OUT_WIDTH + 1)'(1);
    if (x_ref[OUT_WIDTH-1]) begin
      ok = (y == '0);
    end else begin
      ok = (x_ext >= sq_ext) && (x_ext < hi_ext);
    end
  end

endmodule

// File: rtl/cordic_square.sv
// cordic_square: iterative shift-and-add squarer.
// One multiplier bit is consumed per RUN cycle, so the latency is fixed at
// IN_WIDTH RUN cycles plus one FIN cycle regardless of the operand.
// Optional feature: define CORDIC_SQUARE_CHECK_EN to add the root-bound
// check (check_ok); without it check_ok is tied low and x_ref is ignored.
module cordic_square
  import watchdog_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 2 * IN_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  cordic_square_if.slave  bus
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  fsm_state_e state_q, state_d;

  logic [IN_WIDTH-1:0]  mplier_q, mplier_d;
  logic [OUT_WIDTH-1:0] mcand_q,  mcand_d;
  logic [OUT_WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;

  logic accept;
  logic last_run;

  assign accept   = (state_q == IDLE) && bus.start;
  assign last_run = (state_q == RUN) && (cnt_q == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start only matters in IDLE; FIN always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: done is the single FIN cycle, busy covers RUN and FIN.
  always_comb begin
    bus.done = (state_q == FIN);
    bus.busy = (state_q != IDLE);
  end

  // Datapath next values: load on accept, one add/shift step per RUN cycle.
  always_comb begin
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (accept) begin
      mplier_d = bus.y_in;
      mcand_d  = OUT_WIDTH'(bus.y_in);
      acc_d    = '0;
      cnt_d    = CNT_W'(IN_WIDTH);
    end else if (state_q == RUN) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  // Datapath registers; the accumulator doubles as the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.sq_out = acc_q;

`ifdef CORDIC_SQUARE_CHECK_EN
  logic        [IN_WIDTH-1:0]  y_q,    y_d;
  logic signed [OUT_WIDTH-1:0] xref_q, xref_d;
  logic                        chk_q,  chk_d;
  logic                        bound_ok;

  // The final square is acc_d on the last RUN cycle, so the verdict is
  // registered on the same edge that enters FIN and is valid with done.
  sq_bound_check #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_bound (
    .sq    (acc_d),
    .y     (y_q),
    .x_ref (xref_q),
    .ok    (bound_ok)
  );

  // Check operands latch on accept; the verdict clears on accept and holds after FIN.
  always_comb begin
    y_d    = y_q;
    xref_d = xref_q;
    chk_d  = chk_q;
    if (accept) begin
      y_d    = bus.y_in;
      xref_d = bus.x_ref;
      chk_d  = 1'b0;
    end else if (last_run) begin
      chk_d  = bound_ok;
    end
  end

  // Check registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      xref_q <= '0;
      chk_q  <= 1'b0;
    end else begin
      y_q    <= y_d;
      xref_q <= xref_d;
      chk_q  <= chk_d;
    end
  end

  assign bus.check_ok = chk_q;
`else
  assign bus.check_ok = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_square.sv
// Scoreboard bench for cordic_square: the driver pushes the hand-computed
// result of each accepted request; a monitor pops on every done pulse.
module tb_cordic_square;

  localparam int IW = 16;
  localparam int OW = 32;
`ifdef CORDIC_SQUARE_CHECK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  typedef struct {
    logic [OW-1:0] sq;
    bit            chk;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   last_done_cyc;
  exp_t exp_q[$];

  cordic_square_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  cordic_square #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, required no pulse", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sq_out", bus.sq_out, e.sq);
        check("check_ok", OW'(bus.check_ok), OW'(CHK_ON & e.chk));
        check("latency", OW'(cyc), OW'(e.cyc));
        last_done_cyc = cyc;
      end
    end
  end

  // Pulse start for one cycle; optionally record the expected result.
  task automatic issue(input logic [IW-1:0] y, input logic signed [OW-1:0] x,
                       input logic [OW-1:0] sq, input bit chk, input bit push);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.y_in  = y;
    bus.x_ref = x;
    if (push) begin
      e.sq  = sq;
      e.chk = chk;
      e.cyc = cyc + 17;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.y_in  = $urandom();
    bus.x_ref = $urandom();
  endtask

  // Wait (bounded) for done, checking busy stays high until it arrives.
  task automatic wait_done(input string name);
    bit seen;
    bit busy_ok;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    check({name, "_done_seen"}, OW'(seen), OW'(1));
    check({name, "_busy_held"}, OW'(busy_ok), OW'(1));
  endtask

  initial begin
    int d1;
    cyc           = 0;
    checks        = 0;
    errors        = 0;
    last_done_cyc = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.y_in      = '0;
    bus.x_ref     = '0;
    repeat (3) @(negedge clk);
    check("rst_sq_out", bus.sq_out, 0);
    check("rst_done", OW'(bus.done), 0);
    check("rst_busy", OW'(bus.busy), 0);
    check("rst_check_ok", OW'(bus.check_ok), 0);
    rst_n = 1'b1;

    issue(16'd12345, 32'sd0, 32'd152399025, 1'b0, 1'b1);
    wait_done("y12345");
    issue(16'd0, 32'sd0, 32'd0, 1'b1, 1'b1);
    wait_done("y0");
    issue(16'd65535, 32'sd0, 32'd4294836225, 1'b0, 1'b1);
    wait_done("y65535");

    issue(16'd3, 32'sd15, 32'd9, 1'b1, 1'b1);
    wait_done("chk_3_15");
    issue(16'd3, 32'sd16, 32'd9, 1'b0, 1'b1);
    wait_done("chk_3_16");
    issue(16'd0, -32'sd5, 32'd0, 1'b1, 1'b1);
    wait_done("chk_0_neg");
    issue(16'd1, -32'sd5, 32'd1, 1'b0, 1'b1);
    wait_done("chk_1_neg");

    // Start during RUN (cycle 5) must be ignored.
    issue(16'd1000, 32'sd0, 32'd1000000, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.y_in  = 16'd7;
    bus.x_ref = 32'sd49;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored_start");
    repeat (3) @(negedge clk);

    // Reset during RUN cycle 8 aborts without a done pulse.
    issue(16'd500, 32'sd0, 32'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sq_out", bus.sq_out, 0);
    check("abort_busy", OW'(bus.busy), 0);
    check("abort_done", OW'(bus.done), 0);
    check("abort_check_ok", OW'(bus.check_ok), 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'd2, 32'sd4, 32'd4, 1'b1, 1'b1);
    wait_done("after_abort");

    // Back-to-back: restart in the IDLE cycle right after FIN.
    issue(16'd100, 32'sd10000, 32'd10000, 1'b1, 1'b1);
    wait_done("b2b_first");
    d1 = last_done_cyc;
    issue(16'd200, 32'sd40000, 32'd40000, 1'b1, 1'b1);
    wait_done("b2b_second");
    check("b2b_spacing", OW'(last_done_cyc - d1), 32'd18);

    repeat (25) @(negedge clk);
    check("queue_drained", OW'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
